cpu_memory: RTL

//  Memory-access stage of the moxie pipeline, between execute and cpu_write.
//  Non-memory results pass through one register stage.

---
 rtl/cpu_memory_pkg.sv | 22 ++
 rtl/cpu_memory_lane.sv | 46 ++++
 rtl/cpu_memory.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_memory_pkg.sv
// Shared constants and types for the moxie memory-access stage.
package cpu_memory_pkg;

   localparam logic [1:0] MEM_OP_NONE  = 2'd0;
   localparam logic [1:0] MEM_OP_LOAD  = 2'd1;
   localparam logic [1:0] MEM_OP_STORE = 2'd2;

   localparam logic [1:0] MEM_W_BYTE = 2'd0;
   localparam logic [1:0] MEM_W_HALF = 2'd1;
   localparam logic [1:0] MEM_W_WORD = 2'd2;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUS  = 1'b1
   } state_e;

   // Opcode 3 is reserved and behaves like a plain ALU pass-through.
   function automatic logic isMemOp(input logic [1:0] op);
      return (op == MEM_OP_LOAD) || (op == MEM_OP_STORE);
   endfunction

endpackage

// File: rtl/cpu_memory_lane.sv
// Big-endian byte-lane logic: select generation, store steering,
// load extraction with zero extension, and misalignment detection.
module cpu_mem_lane
   import cpu_memory_pkg::*;
(
   input  logic [1:0]  width_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] store_data_i,
   input  logic [31:0] load_data_i,
   output logic [3:0]  sel_o,
   output logic [31:0] store_data_o,
   output logic [31:0] load_data_o,
   output logic        misaligned_o
);

   // Lane 3 (bits 31:24) is the lowest byte address; width 3 behaves as word.
   always_comb begin
      sel_o        = 4'b1111;
      store_data_o = store_data_i;
      load_data_o  = load_data_i;
      misaligned_o = 1'b0;
      case (width_i)
         MEM_W_BYTE: begin
            sel_o        = 4'b1000 >> addr_lo_i;
            store_data_o = {4{store_data_i[7:0]}};
            case (addr_lo_i)
               2'd0:    load_data_o = {24'h0, load_data_i[31:24]};
               2'd1:    load_data_o = {24'h0, load_data_i[23:16]};
               2'd2:    load_data_o = {24'h0, load_data_i[15:8]};
               default: load_data_o = {24'h0, load_data_i[7:0]};
            endcase
         end
         MEM_W_HALF: begin
            sel_o        = addr_lo_i[1] ? 4'b0011 : 4'b1100;
            store_data_o = {2{store_data_i[15:0]}};
            load_data_o  = addr_lo_i[1] ? {16'h0, load_data_i[15:0]}
                                        : {16'h0, load_data_i[31:16]};
            misaligned_o = addr_lo_i[0];
         end
         default: begin
            misaligned_o = (addr_lo_i != 2'b00);
         end
      endcase
   end

endmodule

// File: rtl/cpu_memory.sv
// Memory-access stage of the moxie pipeline: ALU results pass through a
// register, loads/stores run one Wishbone-style bus cycle while stalling
// upstream, with an optional ack timeout.
module cpu_memory
   import cpu_memory_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        valid_i,
   input  logic [1:0]  mem_op_i,
   input  logic [1:0]  mem_width_i,
   input  logic [31:0] mem_addr_i,
   input  logic [31:0] mem_data_i,
   input  logic [31:0] result_i,
   input  logic [3:0]  register_write_index_i,
   input  logic        register_write_enable_i,
   input  logic        flush_i,
   output logic        stall_o,
   output logic [3:0]  register_write_index_o,
   output logic        register_write_enable_o,
   output logic [31:0] result_o,
   output logic        dmem_cyc_o,
   output logic        dmem_stb_o,
   output logic        dmem_we_o,
   output logic [3:0]  dmem_sel_o,
   output logic [31:0] dmem_adr_o,
   output logic [31:0] dmem_dat_o,
   input  logic [31:0] dmem_dat_i,
   input  logic        dmem_ack_i,
   output logic        fault_o
);

   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W:0] TIMEOUT_V = (CNT_W + 1)'(TIMEOUT);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W:0]    nextCnt;
   logic [3:0]        idx_q, idx_d;
   logic              en_q, en_d;
   logic [31:0]       result_q, result_d;
   logic              fault_q, fault_d;
   logic              cyc_q, cyc_d;
   logic              we_q, we_d;
   logic [3:0]        sel_q, sel_d;
   logic [31:0]       adr_q, adr_d;
   logic [31:0]       dat_q, dat_d;
   logic              capEn_q, capEn_d;
   logic [1:0]        capWidth_q, capWidth_d;
   logic [1:0]        capAddrLo_q, capAddrLo_d;

   logic [1:0]        laneWidth;
   logic [1:0]        laneAddrLo;
   logic [3:0]        laneSel;
   logic [31:0]       laneStore;
   logic [31:0]       laneLoad;
   logic              laneMisaligned;

   // One lane unit serves both phases: request decode in IDLE, load extract in BUS.
   assign laneWidth  = (state_q == ST_BUS) ? capWidth_q  : mem_width_i;
   assign laneAddrLo = (state_q == ST_BUS) ? capAddrLo_q : mem_addr_i[1:0];
   assign nextCnt    = {1'b0, cnt_q} + (CNT_W + 1)'(1);

   cpu_mem_lane u_lane (
      .width_i      (laneWidth),
      .addr_lo_i    (laneAddrLo),
      .store_data_i (mem_data_i),
      .load_data_i  (dmem_dat_i),
      .sel_o        (laneSel),
      .store_data_o (laneStore),
      .load_data_o  (laneLoad),
      .misaligned_o (laneMisaligned)
   );

   // Next-state logic: accept/decode in IDLE, wait for ack or timeout in BUS.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      en_d        = en_q;
      result_d    = result_q;
      fault_d     = 1'b0;
      cyc_d       = cyc_q;
      we_d        = we_q;
      sel_d       = sel_q;
      adr_d       = adr_q;
      dat_d       = dat_q;
      capEn_d     = capEn_q;
      capWidth_d  = capWidth_q;
      capAddrLo_d = capAddrLo_q;
      case (state_q)
         ST_IDLE: begin
            en_d  = 1'b0;
            cnt_d = '0;
            if (valid_i && !flush_i) begin
               if (isMemOp(mem_op_i)) begin
                  if (laneMisaligned) begin
                     fault_d = 1'b1;
                  end else begin
                     state_d     = ST_BUS;
                     cyc_d       = 1'b1;
                     we_d        = (mem_op_i == MEM_OP_STORE);
                     sel_d       = laneSel;
                     adr_d       = {mem_addr_i[31:2], 2'b00};
                     dat_d       = laneStore;
                     idx_d       = register_write_index_i;
                     capEn_d     = register_write_enable_i;
                     capWidth_d  = mem_width_i;
                     capAddrLo_d = mem_addr_i[1:0];
                  end
               end else begin
                  idx_d    = register_write_index_i;
                  en_d     = register_write_enable_i;
                  result_d = result_i;
               end
            end
         end
         ST_BUS: begin
            if (dmem_ack_i) begin
               state_d = ST_IDLE;
               cyc_d   = 1'b0;
               we_d    = 1'b0;
               sel_d   = 4'b0000;
               cnt_d   = '0;
               if (!we_q) begin
                  result_d = laneLoad;
                  en_d     = capEn_q;
               end else begin
                  en_d = 1'b0;
               end
            end else if ((TIMEOUT != 0) && (nextCnt == TIMEOUT_V)) begin
               state_d = ST_IDLE;
               cyc_d   = 1'b0;
               we_d    = 1'b0;
               sel_d   = 4'b0000;
               cnt_d   = '0;
               en_d    = 1'b0;
               fault_d = 1'b1;
            end else begin
               cnt_d = nextCnt[CNT_W-1:0];
            end
         end
      endcase
   end

   // State and output registers; reset drops the bus cycle immediately.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         en_q        <= 1'b0;
         result_q    <= '0;
         fault_q     <= 1'b0;
         cyc_q       <= 1'b0;
         we_q        <= 1'b0;
         sel_q       <= '0;
         adr_q       <= '0;
         dat_q       <= '0;
         capEn_q     <= 1'b0;
         capWidth_q  <= '0;
         capAddrLo_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         en_q        <= en_d;
         result_q    <= result_d;
         fault_q     <= fault_d;
         cyc_q       <= cyc_d;
         we_q        <= we_d;
         sel_q       <= sel_d;
         adr_q       <= adr_d;
         dat_q       <= dat_d;
         capEn_q     <= capEn_d;
         capWidth_q  <= capWidth_d;
         capAddrLo_q <= capAddrLo_d;
      end
   end

   assign stall_o                 = (state_q == ST_BUS);
   assign register_write_index_o  = idx_q;
   assign register_write_enable_o = en_q;
   assign result_o                = result_q;
   assign dmem_cyc_o              = cyc_q;
   assign dmem_stb_o              = cyc_q;
   assign dmem_we_o               = we_q;
   assign dmem_sel_o              = sel_q;
   assign dmem_adr_o              = adr_q;
   assign dmem_dat_o              = dat_q;
   assign fault_o                 = fault_q;

endmodule
